// File: rtl/reset_sequencer.sv
// Staged reset generator: synchronised async assertion/release, a hold stretch,
// then per-channel release STAGGER_CYCLES apart, channel 0 first.
module reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int NUM_CHANNELS   = 3,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_async_unsafe_i,
  input  logic                    soft_reset_i,
  output logic [NUM_CHANNELS-1:0] reset_o,
  output logic                    busy_o,
  output logic                    released_o
);

  // state      | meaning
  // ST_ASSERT  | all channels in reset, waiting for the synchroniser
  // ST_HOLD    | stretch count before channel 0 releases
  // ST_STAGGER | releasing channels 1..N-1, one per stagger period
  // ST_RUN     | all channels released

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (NUM_CHANNELS < 1) begin : g_bad_chan
    $error("reset_sequencer: NUM_CHANNELS must be >= 1");
  end
  if (STAGGER_CYCLES < 1) begin : g_bad_stag
    $error("reset_sequencer: STAGGER_CYCLES must be >= 1");
  end

  localparam int MAX_CNT = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int IDX_W   = $clog2(NUM_CHANNELS + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_STAGGER,
    ST_RUN
  } state_t;

  state_t                  r_state;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [NUM_CHANNELS-1:0] r_reset;
  logic                    r_busy;
  logic                    r_released;
  logic                    w_sync_q;

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  // Only stage 0 ever samples the asynchronous release.
  always_ff @(posedge clk_i or negedge reset_n_async_unsafe_i) begin
    if (!reset_n_async_unsafe_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Channels release in index order, so clearing reset_o[r_idx] is the same
  // as shifting a zero in from the bottom; the shift avoids a variable index.
  always_ff @(posedge clk_i or negedge reset_n_async_unsafe_i) begin
    if (!reset_n_async_unsafe_i) begin
      r_state    <= ST_ASSERT;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_reset    <= '1;
      r_busy     <= 1'b1;
      r_released <= 1'b0;
    end else begin
      r_released <= 1'b0;
      if (soft_reset_i && (r_state != ST_ASSERT)) begin
        r_state <= ST_HOLD;
        r_cnt   <= '0;
        r_idx   <= '0;
        r_reset <= '1;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          ST_ASSERT: begin
            if (w_sync_q) begin
              r_state <= ST_HOLD;
              r_cnt   <= '0;
            end
          end
          ST_HOLD: begin
            if (r_cnt == HOLD_LAST) begin
              r_cnt   <= '0;
              r_idx   <= IDX_W'(1);
              r_reset <= r_reset << 1;
              if (NUM_CHANNELS == 1) begin
                r_state    <= ST_RUN;
                r_busy     <= 1'b0;
                r_released <= 1'b1;
              end else begin
                r_state <= ST_STAGGER;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_STAGGER: begin
            if (r_cnt == STAG_LAST) begin
              r_cnt   <= '0;
              r_idx   <= r_idx + IDX_W'(1);
              r_reset <= r_reset << 1;
              if (r_idx == IDX_LAST) begin
                r_state    <= ST_RUN;
                r_busy     <= 1'b0;
                r_released <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_RUN: begin
            r_state <= ST_RUN;
          end
          default: begin
            r_state <= ST_ASSERT;
          end
        endcase
      end
    end
  end

  assign reset_o    = r_reset;
  assign busy_o     = r_busy;
  assign released_o = r_released;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default, single-channel and wide
// instances side by side, checked every cycle against release-edge formulas.
module tb_reset_sequencer;

  logic       clk_sys  = 1'b0;
  logic       rst_b    = 1'b1;
  logic       soft_req = 1'b0;

  logic [2:0] out_d;
  logic       busy_d, rel_d;
  logic [0:0] out_s;
  logic       busy_s, rel_s;
  logic [7:0] out_w;
  logic       busy_w, rel_w;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int org_d   = 1000;
  int org_s   = 1000;
  int org_w   = 1000;

  always #5 clk_sys = ~clk_sys;

  reset_sequencer u_dut_d (
    .clk_i                  (clk_sys),
    .reset_n_async_unsafe_i (rst_b),
    .soft_reset_i           (soft_req),
    .reset_o                (out_d),
    .busy_o                 (busy_d),
    .released_o             (rel_d)
  );

  reset_sequencer #(
    .SYNC_STAGES(3), .HOLD_CYCLES(1), .NUM_CHANNELS(1), .STAGGER_CYCLES(1)
  ) u_dut_s (
    .clk_i                  (clk_sys),
    .reset_n_async_unsafe_i (rst_b),
    .soft_reset_i           (soft_req),
    .reset_o                (out_s),
    .busy_o                 (busy_s),
    .released_o             (rel_s)
  );

  reset_sequencer #(
    .SYNC_STAGES(2), .HOLD_CYCLES(5), .NUM_CHANNELS(8), .STAGGER_CYCLES(7)
  ) u_dut_w (
    .clk_i                  (clk_sys),
    .reset_n_async_unsafe_i (rst_b),
    .soft_reset_i           (soft_req),
    .reset_o                (out_w),
    .busy_o                 (busy_w),
    .released_o             (rel_w)
  );

  // Channel i is still in reset until edge org + H + i*T.
  function automatic logic [31:0] exp_rst(int c, int org, int h, int t, int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      if (c < org + h + i * t) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic exp_rel(int c, int org, int h, int t, int n);
    return (c == org + h + (n - 1) * t);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  task automatic check_inst(input string nm, input logic [31:0] got_rst, input logic got_busy,
                            input logic got_rel, input int org, input int h, input int t,
                            input int n);
    logic [31:0] e;
    e = exp_rst(cyc, org, h, t, n);
    check_eq({nm, "_rst"},  got_rst, e);
    check_eq({nm, "_busy"}, 32'(got_busy), 32'(|e));
    check_eq({nm, "_rel"},  32'(got_rel), 32'(exp_rel(cyc, org, h, t, n)));
  endtask

  task automatic check_all();
    check_inst("dflt", 32'(out_d), busy_d, rel_d, org_d, 16, 4, 3);
    check_inst("one",  32'(out_s), busy_s, rel_s, org_s, 1, 1, 1);
    check_inst("wide", 32'(out_w), busy_w, rel_w, org_w, 5, 7, 8);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic run_to(input int last);
    while (cyc < last) tick();
  endtask

  task automatic hold_all();
    org_d = 1000;
    org_s = 1000;
    org_w = 1000;
  endtask

  // The next rising edge after this call is E0; HOLD is entered at E(S).
  task automatic release_reset();
    rst_b = 1'b1;
    cyc   = -1;
    org_d = 2;
    org_s = 3;
    org_w = 2;
  endtask

  task automatic soft_origin(input int es);
    org_d = es;
    org_s = es;
    org_w = es;
  endtask

  initial begin
    // power-on: assertion must appear before any clock edge
    #2 rst_b = 1'b0;
    #1 check_all();
    repeat (5) tick();
    release_reset();
    run_to(60);

    // sub-period reset pulse while in RUN
    #1 rst_b = 1'b0;
    hold_all();
    #2 check_all();
    #1 release_reset();
    run_to(60);

    // one-cycle soft reset in RUN
    soft_req = 1'b1;
    soft_origin(cyc + 1);
    tick();
    soft_req = 1'b0;
    run_to(130);

    // restart, then hold soft reset for 10 samples mid-stagger
    soft_req = 1'b1;
    soft_origin(cyc + 1);
    tick();
    soft_req = 1'b0;
    run_to(148);
    soft_req = 1'b1;
    soft_origin(cyc + 10);
    repeat (10) tick();
    soft_req = 1'b0;
    run_to(230);

    // soft reset during ASSERT must be ignored
    rst_b    = 1'b0;
    soft_req = 1'b1;
    hold_all();
    #1 check_all();
    repeat (3) tick();
    release_reset();
    tick();
    tick();
    soft_req = 1'b0;
    run_to(60);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset generator: asserts an NUM_CHANNELS-wide active-high reset asynchronously, synchronises the release through a SYNC_STAGES flop chain, stretches it for HOLD_CYCLES, then releases the channels one at a time, STAGGER_CYCLES apart, channel 0 first. It sits at the top of the design between the board reset button and every downstream block, such as the video timing, game logic and audio. It supersedes the fixed two-flop synchroniser, which had one output and no stretch. A synchronous soft-reset request re-runs the hold/stagger sequence without touching the synchroniser.

## Interface

- SYNC_STAGES, 2: synchroniser depth. Must be ≥ 2.
- HOLD_CYCLES, 16: stretch cycles after sync release, before channel 0 releases. Must be ≥ 1.
- NUM_CHANNELS, 3: number of reset outputs. Must be ≥ 1.
- STAGGER_CYCLES, 4: cycles between consecutive channel releases. Must be ≥ 1.
- Illegal parameter values cause an elaboration error.

- clk_i  in  1  single clock.
- reset_n_async_unsafe_i  in  1  reset, asynchronous, active-low.
- soft_reset_i  in  1  synchronous active-high request to re-run the sequence.
- reset_o  out  NUM_CHANNELS  active-high resets. Bit i is the reset for channel i.
- busy_o  out  1  high while any reset_o bit is asserted.
- released_o  out  1  one-cycle pulse when the last channel releases.

## Operation

- States:
  - ASSERT: waiting for the synchroniser.
  - HOLD: stretch count.
  - STAGGER: channel release.
  - RUN: all channels released.
- Reset value: while reset_n_async_unsafe_i is low, all flops clear asynchronously.
  - Sync chain = 0, state = ASSERT, counters = 0.
  - reset_o = all ones, busy_o = 1, released_o = 0.
  - Assertion needs no clock.
- Synchroniser: shift register with 1 shifted in. sync_q is its last stage.
- ASSERT → HOLD: on the first edge at which sync_q = 1. Counter cleared.
- HOLD: the counter increments each edge. On the edge where counter = HOLD_CYCLES−1:
  - go to STAGGER;
  - clear reset_o[0];
  - set channel index = 1 and counter = 0.
- STAGGER: on the edge where counter = STAGGER_CYCLES−1:
  - clear reset_o[index] and increment index;
  - reset the counter.
- STAGGER → RUN: on the edge that clears reset_o[NUM_CHANNELS−1]. On that same edge busy_o → 0 and released_o → 1; released_o → 0 on the next edge.
- NUM_CHANNELS = 1: HOLD → RUN directly on the release edge.
- soft_reset_i sampled high in HOLD, STAGGER or RUN:
  - on that edge: reset_o = all ones, busy_o = 1, state = HOLD, counter = 0, released_o = 0;
  - if held high, the block stays in HOLD with counter = 0;
  - the request is ignored in ASSERT.
- Soft reset and the counter terminal value on the same edge: soft reset wins.
- Async reset mid-sequence, or in RUN, restarts everything, including the synchroniser.
- A reset_n low pulse shorter than a clock period still asserts fully.
- Invariant: reset_o[i] = 0 implies reset_o[j] = 0 for all j < i. Release order is strictly monotonic.
- Counter width: $clog2(max(HOLD_CYCLES, STAGGER_CYCLES)). Index width: $clog2(NUM_CHANNELS+1).

## Timing

- Let E0 be the first rising edge with reset_n high that meets setup.
- sync_q rises at E(S−1) and HOLD is entered at E(S), where S = SYNC_STAGES.
- Channel i releases at E(S + H + i·T), where H = HOLD_CYCLES and T = STAGGER_CYCLES.
- busy_o falls, and released_o pulses, at E(S + H + (N−1)·T).
- Defaults: channels release at E18, E22 and E26; released_o is high E26 to E27.
- Soft reset sampled at edge Es: channel i releases at Es + H + i·T.
- Assertion latency:
  - async reset: combinational through the flop clear, zero edges;
  - soft reset: one edge.
- Metastability exposure is confined to sync chain stage 0.

## Test plan

- Power-on with defaults, reset_n low for 5 cycles then high → reset_o = 3'b111 until E18, then 3'b110, 3'b100 at E22, 3'b000 at E26; released_o high for exactly one cycle, at E26.
- reset_n pulsed low for 3 ns (less than one period) while in RUN → reset_o = 3'b111 immediately; the full sequence replays with the same edge offsets.
- soft_reset_i high for one cycle at Es in RUN → reset_o = 3'b111 at Es; releases at Es+16, Es+20, Es+24; sync chain unaffected.
- soft_reset_i held high for 10 cycles during STAGGER (after channel 0 released) → all channels reasserted; channel 0 releases 16 edges after the last high sample.
- Parameter sweep (S=3, H=1, T=1, N=1) and (S=2, H=5, T=7, N=8) → release edges match E(S+H+i·T); the monotonic-order invariant and busy_o = |reset_o hold every cycle.
- soft_reset_i asserted while still in ASSERT → ignored; timing identical to the power-on case.
